// File: rtl/cfg_chain_loader_if.sv
// Bitstream stream interface between a bitstream source and cfg_chain_loader.
//   s_data_i  : bitstream word (source -> loader)
//   s_valid_i : s_data_i is valid (source -> loader)
//   s_ready_o : loader accepts a word this cycle (loader -> source)
// master = bitstream source, slave = loader.
interface cfg_chain_loader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] s_data_i;
    logic             s_valid_i;
    logic             s_ready_o;

    modport master (output s_data_i, output s_valid_i, input s_ready_o);
    modport slave  (input s_data_i, input s_valid_i, output s_ready_o);
endinterface

// File: rtl/cfg_chain_loader.sv
// Configuration chain controller for one eFPGA configuration column.
// Shifts a WIDTH-bit bitstream into the head of a tile configuration chain
// (LOAD pass), or recirculates the chain tail into the head for one full
// chain length and compares a rolling checksum against the load-time one
// (VERIFY pass, non-destructive).
// Ports:
//   clk, nres      : clock, async active-low reset
//   start_i        : one-cycle load request (wins over verify_i)
//   verify_i       : one-cycle verify request
//   s_if           : bitstream valid/ready stream (slave side)
//   chain_d_o      : word into chain head (prog_i)
//   chain_shft_o   : chain shift enable (prog_shft)
//   chain_q_i      : chain tail word (prog_o)
//   busy_o         : LOAD or VERIFY in progress
//   done_o         : one-cycle pulse at end of a pass
//   sum_o          : checksum captured by the last completed load
//   match_o        : last verify checksum equals sum_o
module cfg_chain_loader #(
    parameter int WIDTH     = 32,
    parameter int CHAIN_LEN = 72
) (
    input  logic             clk,
    input  logic             nres,
    input  logic             start_i,
    input  logic             verify_i,
    cfg_chain_loader_if.slave s_if,
    output logic [WIDTH-1:0] chain_d_o,
    output logic             chain_shft_o,
    input  logic [WIDTH-1:0] chain_q_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             match_o
);
    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] run_sum;

    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] s,
                                              input logic [WIDTH-1:0] w);
        return {s[WIDTH-2:0], s[WIDTH-1]} ^ w;
    endfunction

    logic             in_load, in_verify, xfer;
    logic [WIDTH-1:0] load_sum, vfy_sum;

    assign in_load   = (state == ST_LOAD);
    assign in_verify = (state == ST_VERIFY);
    assign xfer      = in_load && s_if.s_valid_i;
    assign load_sum  = fold(run_sum, s_if.s_data_i);
    assign vfy_sum   = fold(run_sum, chain_q_i);

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            run_sum <= '0;
            sum_o   <= '0;
            match_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state   <= ST_LOAD;
                        cnt     <= '0;
                        run_sum <= '0;
                        match_o <= 1'b0;
                    end else if (verify_i) begin
                        state   <= ST_VERIFY;
                        cnt     <= '0;
                        run_sum <= '0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        run_sum <= load_sum;
                        if (cnt == CNT_LAST) begin
                            state <= ST_DONE;
                            sum_o <= load_sum;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    // Tail word is shifted back into the head every cycle,
                    // so the chain returns to its original contents.
                    run_sum <= vfy_sum;
                    if (cnt == CNT_LAST) begin
                        state   <= ST_DONE;
                        match_o <= (vfy_sum == sum_o);
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        chain_d_o    = '0;
        chain_shft_o = 1'b0;
        if (in_load) begin
            chain_d_o    = s_if.s_data_i;
            chain_shft_o = s_if.s_valid_i;
        end else if (in_verify) begin
            chain_d_o    = chain_q_i;
            chain_shft_o = 1'b1;
        end
    end

    assign s_if.s_ready_o = in_load;
    assign busy_o         = in_load || in_verify;
    assign done_o         = (state == ST_DONE);
endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Configuration chain controller for the eFPGA fabric. It accepts a bitstream as a stream of WIDTH-bit words over a valid/ready handshake and shifts them into the head of a tile configuration shift chain (crossbar/switch-box `prog_i`/`prog_shft`/`prog_o` chains). It then optionally runs a non-destructive verify pass, which recirculates the chain tail back into its head for exactly one chain length and compares a rolling checksum against the one taken at load time. One instance sits at the head of each configuration column.

## Interface
- `WIDTH`, 32, configuration word width (equals chain word width).
- `CHAIN_LEN`, 72, number of words in the attached chain (16 SE + 8 SW + 32 NE + 16 NW).
- `clk`  in  1  clock; all state updates on the rising edge.
- `nres`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  single-cycle request to begin a load pass.
- `verify_i`  in  1  single-cycle request to begin a verify pass.
- `s_data_i`  in  WIDTH  bitstream word.
- `s_valid_i`  in  1  `s_data_i` is valid.
- `s_ready_o`  out  1  loader accepts a word this cycle.
- `chain_d_o`  out  WIDTH  word driven into the chain head (`prog_i` of the first tile).
- `chain_shft_o`  out  1  chain shift enable (`prog_shft` of every tile in the chain).
- `chain_q_i`  in  WIDTH  chain tail word (`prog_o` of the last tile).
- `busy_o`  out  1  a pass (LOAD or VERIFY) is in progress.
- `done_o`  out  1  one-cycle pulse at the end of a pass.
- `sum_o`  out  WIDTH  checksum captured by the last completed load.
- `match_o`  out  1  last verify checksum equals `sum_o`.

## Operation
- States: IDLE, LOAD, VERIFY, DONE. Word counter `cnt` ranges over 0..CHAIN_LEN-1.
- Checksum step: `sum' = rotl1(sum) ^ word`, where `rotl1(x) = {x[WIDTH-2:0], x[WIDTH-1]}`. The running sum is cleared at pass start.
- IDLE: if `start_i` is high, go to LOAD and clear `cnt`, the running sum and `match_o`. Else if `verify_i` is high, go to VERIFY and clear `cnt` and the running sum. `start_i` wins when both are high. Both requests are ignored outside IDLE.
- LOAD:
  - `s_ready_o` is high. `chain_d_o = s_data_i` and `chain_shft_o = s_valid_i` (combinational).
  - On each transfer (`s_valid_i` high), fold the word into the running sum and increment `cnt`.
  - On the transfer with `cnt == CHAIN_LEN-1`, go to DONE and load `sum_o` with the final sum.
- VERIFY:
  - `chain_d_o = chain_q_i` and `chain_shft_o = 1` every cycle. Fold `chain_q_i` into the running sum each cycle.
  - After CHAIN_LEN cycles, go to DONE and set `match_o = (final sum == sum_o)`.
  - Because the first word loaded sits at the tail, recirculation presents the words in load order. The chain contents are unchanged after the pass.
- DONE: `done_o = 1` for one cycle, then return to IDLE.
- Outside LOAD and VERIFY: `chain_shft_o = 0`, `chain_d_o = 0`, `s_ready_o = 0`.
- `busy_o` is high in LOAD and VERIFY only.
- Partial load: the pass stays in LOAD indefinitely until CHAIN_LEN words have been transferred. There is no timeout.
- Verify before any load: compares against `sum_o = 0`. `match_o` is set only if the chain checksum is also 0.

## Timing
- Reset values (asynchronous, while `nres` is low): state IDLE, `cnt = 0`, running sum 0, `sum_o = 0`, `match_o = 0`, `done_o = 0`, `busy_o = 0`, `s_ready_o = 0`, `chain_shft_o = 0`, `chain_d_o = 0`.
- Reset asserted mid-pass aborts immediately. Chain contents are then undefined, and no `done_o` is produced.
- A request sampled at edge t puts the state in LOAD/VERIFY from edge t. `s_ready_o` and `chain_shft_o` can go high in cycle t+1.
- Load with `s_valid_i` continuously high: CHAIN_LEN cycles of shifting, then `done_o` in the following cycle. Total request-to-done latency is CHAIN_LEN+1 cycles.
- Gaps in `s_valid_i` stall the pass 1:1 and produce no chain shift.
- Verify: exactly CHAIN_LEN cycles with `chain_shft_o` high, then `done_o`. `match_o` is valid in the same cycle as `done_o` and holds until the next load start or reset.
- `sum_o` updates at the edge that enters DONE after a load, and holds otherwise.
- The chain registers capture `chain_d_o` on the same edge that the loader counts the word.

## Test plan
- CHAIN_LEN=4, reset released, `start_i` pulse, words 0x1, 0x2, 0x3, 0x4 with valid always high -> exactly 4 shift cycles, `done_o` in cycle 5, `sum_o = 0x00000002`, chain tail holds 0x1.
- Same load followed by a `verify_i` pulse -> 4 shift cycles with `chain_d_o` equal to the tail, `match_o = 1`, chain contents unchanged (a second verify also gives `match_o = 1`).
- Load 0x1–0x4, then the bench corrupts one chain word to 0x5 -> verify gives `match_o = 0`, and `sum_o` stays 0x00000002.
- Load with `s_valid_i` toggling every other cycle -> `chain_shft_o` pulses only on valid cycles, `done_o` after the 4th transfer, same `sum_o`.
- `start_i` and `verify_i` high together in IDLE -> LOAD entered. A `start_i` pulse during LOAD is ignored and the word count is unaffected.
- `nres` low after 2 of 4 words -> all outputs at reset values immediately, and no `done_o`. A new full load then completes normally with `sum_o = 0x00000002`.
